// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver: FSM state encoding, default width,
// minimum oversample ratio and small helpers.
package uart_rx_pkg;

  localparam int         DATA_WIDTH_DEF = 8;
  localparam logic [4:0] MIN_PRESCALE   = 5'd4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_OUT    = 3'd5
  } state_e;

  function automatic logic [4:0] clamp_prescale(input logic [4:0] p);
    return (p < MIN_PRESCALE) ? MIN_PRESCALE : p;
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit timing for the UART receiver: edge counter, bit-end tick and
// 2-of-3 majority around the bit centre.
module uart_rx_sampler
  import uart_rx_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       run_i,
  input  logic       rx_i,
  input  logic [4:0] presc_i,
  output logic       maj_o,
  output logic       tick_o,
  output logic       bit_end_o
);

  logic [4:0] cnt_q, cnt_d;
  logic [1:0] smp_q, smp_d;
  logic [4:0] mid;

  assign mid       = {1'b0, presc_i[4:1]};
  assign bit_end_o = (cnt_q == presc_i - 5'd1);
  assign tick_o    = (cnt_q == mid + 5'd1);
  // Third sample is the live line at mid+1, so the decision lands on the edge
  // that makes the registered result visible at mid+2.
  assign maj_o     = maj3(smp_q[0], smp_q[1], rx_i);

  always_comb begin
    cnt_d = cnt_q;
    smp_d = smp_q;
    if (!run_i || bit_end_o) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 5'd1;
    end
    if (cnt_q == mid - 5'd1) smp_d[0] = rx_i;
    if (cnt_q == mid)        smp_d[1] = rx_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      smp_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      smp_q <= smp_d;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver top: frame FSM, shift register, parity check, output register.
// Define UART_RX_ERR_FLAGS_EN to add Par_Err / Stp_Err drop pulses.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [4:0]            Prescaler,
  output logic [DATA_WIDTH-1:0] P_Data,
  output logic                  Data_Valid
`ifdef UART_RX_ERR_FLAGS_EN
  ,
  output logic                  Par_Err,
  output logic                  Stp_Err
`endif
);

  localparam int             BCW      = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_WIDTH - 1);

  state_e                  state_q, state_d;
  logic [4:0]              presc_q, presc_d;
  logic                    par_en_q, par_en_d;
  logic                    par_typ_q, par_typ_d;
  logic                    par_err_q, par_err_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic [BCW-1:0]          bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0]   p_data_q;
  logic                    dv_q;
  logic                    load;
  logic                    maj, tick, bit_end;

  uart_rx_sampler u_sampler (
    .clk_i     (CLK),
    .rst_i     (RST),
    .run_i     (state_d != ST_IDLE),
    .rx_i      (RX_IN),
    .presc_i   (presc_q),
    .maj_o     (maj),
    .tick_o    (tick),
    .bit_end_o (bit_end)
  );

  always_ff @(posedge CLK) begin
    if (RST) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (!RX_IN) state_d = ST_START;
      ST_START: begin
        if (tick && maj)  state_d = ST_IDLE;
        else if (bit_end) state_d = ST_DATA;
      end
      ST_DATA:   if (bit_end && bit_cnt_q == LAST_BIT) state_d = par_en_q ? ST_PARITY : ST_STOP;
      ST_PARITY: if (bit_end) state_d = ST_STOP;
      ST_STOP:   if (tick) state_d = (maj && !par_err_q) ? ST_OUT : ST_IDLE;
      ST_OUT:    state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

`ifdef UART_RX_ERR_FLAGS_EN
  logic drop_par, drop_stp;
  logic par_err_pulse_q, stp_err_pulse_q;
`endif

  always_comb begin
    presc_d   = presc_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    par_err_d = par_err_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    load      = 1'b0;
`ifdef UART_RX_ERR_FLAGS_EN
    drop_par  = 1'b0;
    drop_stp  = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        // Frame settings are frozen here so mid-frame input changes are ignored.
        if (!RX_IN) begin
          presc_d   = clamp_prescale(Prescaler);
          par_en_d  = PAR_EN;
          par_typ_d = PAR_TYP;
          par_err_d = 1'b0;
          bit_cnt_d = '0;
        end
      end
      ST_DATA: begin
        if (tick)    shift_d   = {maj, shift_q[DATA_WIDTH-1:1]};
        if (bit_end) bit_cnt_d = bit_cnt_q + BCW'(1);
      end
      ST_PARITY: begin
        if (tick && (maj != (^shift_q ^ par_typ_q))) par_err_d = 1'b1;
      end
`ifdef UART_RX_ERR_FLAGS_EN
      ST_STOP: begin
        if (tick) begin
          drop_par = par_err_q;
          drop_stp = !maj && !par_err_q;
        end
      end
`endif
      ST_OUT:  load = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      presc_q   <= MIN_PRESCALE;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      par_err_q <= 1'b0;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      p_data_q  <= '0;
      dv_q      <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      par_err_q <= par_err_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      dv_q      <= load;
      if (load) p_data_q <= shift_q;
    end
  end

  assign P_Data     = p_data_q;
  assign Data_Valid = dv_q;

`ifdef UART_RX_ERR_FLAGS_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      par_err_pulse_q <= 1'b0;
      stp_err_pulse_q <= 1'b0;
    end else begin
      par_err_pulse_q <= drop_par;
      stp_err_pulse_q <= drop_stp;
    end
  end

  assign Par_Err = par_err_pulse_q;
  assign Stp_Err = stp_err_pulse_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: vector table, hand-written corner sequences and random
// frames scored against a frame-level model of the receiver.
module tb_uart_rx;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       RX_IN = 1'b1;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic [4:0] Prescaler = 5'd8;
  logic [7:0] P_Data;
  logic       Data_Valid;
`ifdef UART_RX_ERR_FLAGS_EN
  logic       Par_Err, Stp_Err;
`endif

  uart_rx dut (
    .CLK        (CLK),
    .RST        (RST),
    .RX_IN      (RX_IN),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .Prescaler  (Prescaler),
    .P_Data     (P_Data),
    .Data_Valid (Data_Valid)
`ifdef UART_RX_ERR_FLAGS_EN
    ,
    .Par_Err    (Par_Err),
    .Stp_Err    (Stp_Err)
`endif
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [7:0] pulse_data[$];
  int         pulse_cyc[$];
  logic [7:0] exp_data_q[$];
  int         exp_cyc_q[$];
  logic [7:0] last_exp = 8'h00;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (!RST && Data_Valid) begin
      pulse_data.push_back(P_Data);
      pulse_cyc.push_back(cyc);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_bit(input logic b, input int n);
    RX_IN = b;
    repeat (n) @(posedge CLK);
    #1;
  endtask

  function automatic int eff_presc(input logic [4:0] p);
    return (p < 5'd4) ? 4 : int'(p);
  endfunction

  // Frame-level reference: accepted iff parity (when present) and stop are right.
  function automatic bit model_good(input logic [7:0] d, input logic pe, input logic pt,
                                    input logic pbit, input logic sbit);
    return (sbit == 1'b1) && (!pe || (pbit == (^d ^ pt)));
  endfunction

  task automatic send_frame(input logic [7:0] d, input logic pe, input logic pt,
                            input logic pbit, input logic sbit, input logic [4:0] presc,
                            input int gap, input bit scramble, output int t0);
    int p;
    p = eff_presc(presc);
    Prescaler = presc;
    PAR_EN    = pe;
    PAR_TYP   = pt;
    drive_bit(1'b0, 1);
    if (scramble) begin
      Prescaler = 5'($urandom);
      PAR_EN    = 1'($urandom);
      PAR_TYP   = 1'($urandom);
    end
    drive_bit(1'b0, p - 1);
    for (int i = 0; i < 8; i++) drive_bit(d[i], p);
    if (pe) drive_bit(pbit, p);
    Prescaler = presc;
    PAR_EN    = pe;
    PAR_TYP   = pt;
    t0 = cyc;
    drive_bit(sbit, p);
    drive_bit(1'b1, gap);
  endtask

  task automatic expect_pulse(input logic [7:0] d, input int t0, input logic [4:0] presc);
    exp_data_q.push_back(d);
    exp_cyc_q.push_back(t0 + (eff_presc(presc) >> 1) + 3);
    last_exp = d;
  endtask

  task automatic flush(input string name);
    check({name, "_pulses"}, pulse_data.size(), exp_data_q.size());
    while (pulse_data.size() > 0 && exp_data_q.size() > 0) begin
      check({name, "_data"}, pulse_data.pop_front(), exp_data_q.pop_front());
      check({name, "_cycle"}, pulse_cyc.pop_front(), exp_cyc_q.pop_front());
    end
    check({name, "_hold"}, P_Data, last_exp);
    $display("frame %s: P_Data=0x%02h checks=%0d errors=%0d", name, P_Data, checks, errors);
    pulse_data.delete();
    pulse_cyc.delete();
    exp_data_q.delete();
    exp_cyc_q.delete();
  endtask

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       pt;
    logic       pbit;
    logic       sbit;
    logic [4:0] presc;
    bit         exp_pulse;
    logic [7:0] exp_pdata;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int t0, t1;
    vecs[0] = '{8'hA3, 1'b1, 1'b0, 1'b0, 1'b1, 5'd8,  1'b1, 8'hA3};
    vecs[1] = '{8'hD3, 1'b1, 1'b1, 1'b0, 1'b1, 5'd8,  1'b1, 8'hD3};
    vecs[2] = '{8'hD3, 1'b1, 1'b1, 1'b1, 1'b1, 5'd8,  1'b0, 8'hD3};
    vecs[3] = '{8'h51, 1'b0, 1'b0, 1'b0, 1'b1, 5'd8,  1'b1, 8'h51};
    vecs[4] = '{8'hD1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd8,  1'b0, 8'h51};
    vecs[5] = '{8'hD1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd8,  1'b1, 8'hD1};
    vecs[6] = '{8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 5'd4,  1'b1, 8'h3C};
    vecs[7] = '{8'h96, 1'b0, 1'b0, 1'b0, 1'b1, 5'd2,  1'b1, 8'h96};
    vecs[8] = '{8'hE7, 1'b1, 1'b1, 1'b1, 1'b1, 5'd31, 1'b1, 8'hE7};
    vecs[9] = '{8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 5'd5,  1'b0, 8'hE7};

    // Reset state
    repeat (3) @(posedge CLK);
    #1;
    check("reset_pdata", P_Data, 0);
    check("reset_dv", Data_Valid, 0);
    RST = 1'b0;
    drive_bit(1'b1, 5);

    // Table vectors
    for (int i = 0; i < 10; i++) begin
      send_frame(vecs[i].d, vecs[i].pe, vecs[i].pt, vecs[i].pbit, vecs[i].sbit,
                 vecs[i].presc, eff_presc(vecs[i].presc) + 6, 1'b0, t0);
      if (vecs[i].exp_pulse) expect_pulse(vecs[i].exp_pdata, t0, vecs[i].presc);
      last_exp = vecs[i].exp_pdata;
      flush($sformatf("vec%0d", i));
    end

    // Short start glitch is rejected
    Prescaler = 5'd8;
    drive_bit(1'b0, 2);
    drive_bit(1'b1, 24);
    flush("glitch");

    // Back-to-back frames with no idle gap
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 5'd16, 0, 1'b0, t0);
    send_frame(8'hAA, 1'b0, 1'b0, 1'b0, 1'b1, 5'd16, 24, 1'b0, t1);
    expect_pulse(8'h55, t0, 5'd16);
    expect_pulse(8'hAA, t1, 5'd16);
    flush("b2b");

    // Reset in the middle of the data bits
    Prescaler = 5'd8;
    PAR_EN    = 1'b0;
    drive_bit(1'b0, 8);
    drive_bit(1'b1, 8);
    drive_bit(1'b0, 8);
    drive_bit(1'b1, 4);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    check("rst_mid_pdata", P_Data, 0);
    check("rst_mid_dv", Data_Valid, 0);
    RST = 1'b0;
    drive_bit(1'b1, 20);
    last_exp = 8'h00;
    flush("rst_mid");
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 5'd8, 14, 1'b0, t0);
    expect_pulse(8'h3C, t0, 5'd8);
    flush("after_rst");

    // Random frames against the frame-level model
    for (int n = 0; n < 40; n++) begin
      logic [7:0] d;
      logic       pe, pt, pbit, sbit;
      logic [4:0] presc;
      d     = 8'($urandom);
      pe    = 1'($urandom);
      pt    = 1'($urandom);
      presc = 5'($urandom_range(0, 31));
      pbit  = (^d ^ pt) ^ ($urandom_range(0, 3) == 0);
      sbit  = ($urandom_range(0, 5) != 0);
      send_frame(d, pe, pt, pbit, sbit, presc,
                 eff_presc(presc) + 6 + int'($urandom_range(0, 4)), 1'b1, t0);
      if (model_good(d, pe, pt, pbit, sbit)) expect_pulse(d, t0, presc);
      flush($sformatf("rnd%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
